// File: rtl/uart_frame_sched.sv
// uart_frame_sched: frames FFT result words for the byte-wide UART transmitter.
// Frame layout: SYNC_BYTE, length byte, N_WORDS words (high byte first), 8-bit checksum.
// The RAM read address is presented before the data is needed (one cycle of latency).
module uart_frame_sched #(
  parameter int unsigned N_WORDS   = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 8192,
  localparam int unsigned AW       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_req,
  output logic          o_busy,
  output logic [AW-1:0] o_rd_addr,
  input  logic [15:0]   i_rd_data,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_byte,
  input  logic          i_tx_busy,
  input  logic          i_tx_done,
  output logic          o_frame_done,
  output logic          o_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StLen,
    StRd,
    StHi,
    StLo,
    StCsum,
    StWait,
    StFin
  } state_e;

  state_e        state_q;
  state_e        next_q;
  logic          pending_q;
  logic [7:0]    csum_q;
  logic [7:0]    lo_q;
  logic [TW-1:0] tmo_q;

  logic          is_launch;
  logic [7:0]    launch_byte;
  state_e        launch_next;
  logic          last_word;

  assign last_word = (o_rd_addr == AW'(N_WORDS - 1));

  // Byte and follow-on state for whichever launch state is current.
  always_comb begin
    is_launch   = 1'b0;
    launch_byte = 8'h00;
    launch_next = StIdle;
    case (state_q)
      StHdr: begin
        is_launch   = 1'b1;
        launch_byte = SYNC_BYTE;
        launch_next = StLen;
      end
      StLen: begin
        is_launch   = 1'b1;
        launch_byte = 8'(N_WORDS);
        launch_next = StRd;
      end
      StHi: begin
        is_launch   = 1'b1;
        launch_byte = i_rd_data[15:8];
        launch_next = StLo;
      end
      StLo: begin
        is_launch   = 1'b1;
        launch_byte = lo_q;
        launch_next = last_word ? StCsum : StRd;
      end
      StCsum: begin
        is_launch   = 1'b1;
        launch_byte = csum_q;
        launch_next = StFin;
      end
      default: ;
    endcase
  end

  // Frame sequencer: state, handshake outputs, checksum, pending request and timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      next_q       <= StIdle;
      pending_q    <= 1'b0;
      csum_q       <= 8'h00;
      lo_q         <= 8'h00;
      tmo_q        <= '0;
      o_busy       <= 1'b0;
      o_rd_addr    <= '0;
      o_tx_start   <= 1'b0;
      o_tx_byte    <= 8'h00;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      // One-deep request queue; later branches may clear it.
      if (o_busy && i_frame_req) pending_q <= 1'b1;

      if (is_launch) begin
        // Launch states hold and retry while the transmitter is busy.
        if (!i_tx_busy) begin
          o_tx_start <= 1'b1;
          o_tx_byte  <= launch_byte;
          tmo_q      <= '0;
          next_q     <= launch_next;
          state_q    <= StWait;
          if (state_q != StCsum) csum_q <= csum_q + launch_byte;
          if (state_q == StHi) lo_q <= i_rd_data[7:0];
          if (state_q == StLo && !last_word) o_rd_addr <= o_rd_addr + AW'(1);
        end
      end else begin
        case (state_q)
          StIdle: begin
            o_rd_addr <= '0;
            if ((i_frame_req || pending_q) && !i_tx_busy) begin
              state_q <= StHdr;
              csum_q  <= 8'h00;
              o_busy  <= 1'b1;
              // A request arriving while a queued frame is taken stays queued.
              pending_q <= pending_q && i_frame_req && o_busy;
            end
          end
          StRd: state_q <= StHi;
          StWait: begin
            if (i_tx_done) begin
              state_q <= next_q;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              o_err     <= 1'b1;
              o_busy    <= 1'b0;
              o_rd_addr <= '0;
              pending_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          StFin: begin
            o_frame_done <= 1'b1;
            o_rd_addr    <= '0;
            state_q      <= StIdle;
            // Stay busy across back-to-back frames when another one is queued.
            o_busy       <= pending_q || i_frame_req;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched with a small TX model and a synchronous RAM model.
module tb_uart_frame_sched;

  localparam int unsigned N_WORDS  = 16;
  localparam int unsigned TIMEOUT  = 64;
  localparam int          BYTE_CYC = 40;  // 10 bits at 4 clocks per bit

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_frame_req;
  logic        o_busy;
  logic [3:0]  o_rd_addr;
  logic [15:0] i_rd_data;
  logic        o_tx_start;
  logic [7:0]  o_tx_byte;
  logic        i_tx_busy;
  logic        i_tx_done;
  logic        o_frame_done;
  logic        o_err;

  logic        tx_busy_m;
  logic        force_busy;
  int          tx_cnt;
  int          tx_launches;
  int          withhold_at;

  logic [15:0] mem [N_WORDS];

  int          checks = 0;
  int          errors = 0;

  // Monitor state.
  int          cyc = 0;
  int          frames = 0;
  int          errs = 0;
  int          busy_falls = 0;
  int          start_busy_viol = 0;
  int          stable_viol = 0;
  int          last_done_cyc = 0;
  int          fd_lat = 0;
  int          err_cyc = 0;
  logic        busy_at_fd = 1'b0;
  logic        busy_at_err = 1'b0;
  logic [3:0]  addr_at_err = 4'h0;
  logic        busy_prev = 1'b0;
  logic [7:0]  last_byte = 8'h00;
  logic [7:0]  bytes [$];
  int          lat_q [$];
  int          lcyc [$];

  uart_frame_sched #(
    .N_WORDS  (N_WORDS),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_req (i_frame_req),
    .o_busy      (o_busy),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_tx_start  (o_tx_start),
    .o_tx_byte   (o_tx_byte),
    .i_tx_busy   (i_tx_busy),
    .i_tx_done   (i_tx_done),
    .o_frame_done(o_frame_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  assign i_tx_busy = tx_busy_m | force_busy;

  // Synchronous-read result RAM, one cycle of latency.
  always @(posedge i_clk) i_rd_data <= mem[o_rd_addr];

  // TX model: busy for BYTE_CYC cycles per launch, then a one-cycle done pulse.
  initial begin
    tx_busy_m   = 1'b0;
    i_tx_done   = 1'b0;
    tx_cnt      = 0;
    tx_launches = 0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (o_tx_start === 1'b1) begin
        tx_busy_m   = 1'b1;
        tx_cnt      = BYTE_CYC;
        tx_launches = tx_launches + 1;
      end else if (tx_busy_m) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) begin
          tx_busy_m = 1'b0;
          i_tx_done = (tx_launches != withhold_at);
        end
      end
    end
  end

  // Monitor: records launched bytes, latencies and event cycles.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      cyc = cyc + 1;
      if (i_rst === 1'b1) begin
        last_byte = 8'h00;
      end else begin
        if (o_tx_start === 1'b1) begin
          bytes.push_back(o_tx_byte);
          lat_q.push_back(cyc - last_done_cyc);
          lcyc.push_back(cyc);
          last_byte = o_tx_byte;
          if (i_tx_busy) start_busy_viol = start_busy_viol + 1;
        end else if (o_tx_byte !== last_byte) begin
          stable_viol = stable_viol + 1;
        end
        if (i_tx_done) last_done_cyc = cyc;
        if (o_frame_done === 1'b1) begin
          frames     = frames + 1;
          fd_lat     = cyc - last_done_cyc;
          busy_at_fd = o_busy;
        end
        if (o_err === 1'b1) begin
          errs        = errs + 1;
          err_cyc     = cyc;
          busy_at_err = o_busy;
          addr_at_err = o_rd_addr;
        end
      end
      if (busy_prev && o_busy !== 1'b1) busy_falls = busy_falls + 1;
      busy_prev = (o_busy === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic pulse_req();
    @(negedge i_clk);
    i_frame_req = 1'b1;
    @(negedge i_clk);
    i_frame_req = 1'b0;
  endtask

  // which: 0 = launched bytes, 1 = frames done, 2 = aborts
  task automatic wait_cnt(input int which, input int target, input int max_cyc, input string tag);
    int n;
    int cur;
    n = 0;
    cur = (which == 0) ? bytes.size() : (which == 1) ? frames : errs;
    while (cur < target && n < max_cyc) begin
      tick();
      n = n + 1;
      cur = (which == 0) ? bytes.size() : (which == 1) ? frames : errs;
    end
    chk(tag, 32'(cur >= target), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] cs);
    int w;
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h10;
    if (i == 34) return cs;
    w = (i - 2) / 2;
    return (i % 2 == 0) ? mem[w][15:8] : mem[w][7:0];
  endfunction

  task automatic check_frame(input int base, input logic [7:0] cs, input string tag);
    int bad;
    bad = -1;
    chk({tag, " complete"}, 32'(bytes.size() >= base + 35), 32'd1);
    if (bytes.size() >= base + 35) begin
      for (int i = 0; i < 35; i++) begin
        if (bytes[base + i] !== exp_byte(i, cs) && bad < 0) bad = i;
      end
      chk({tag, " first bad byte index"}, 32'(bad), 32'hFFFF_FFFF);
      chk({tag, " checksum"}, 32'(bytes[base + 34]), 32'(cs));
    end
  endtask

  initial begin
    int b;
    int f0;
    int e0;
    int bf0;

    i_rst       = 1'b0;
    i_frame_req = 1'b0;
    force_busy  = 1'b0;
    withhold_at = 0;
    for (int k = 0; k < N_WORDS; k++) mem[k] = 16'h0000;
    #2 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    chk("reset o_busy", 32'(o_busy), 32'd0);
    chk("reset o_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("reset o_tx_start", 32'(o_tx_start), 32'd0);
    chk("reset o_tx_byte", 32'(o_tx_byte), 32'd0);
    chk("reset o_frame_done", 32'(o_frame_done), 32'd0);
    chk("reset o_err", 32'(o_err), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) tick();

    // All-zero buffer: A5, 10, 00 x 32, B5.
    b = bytes.size(); f0 = frames; e0 = errs;
    @(negedge i_clk);
    i_frame_req = 1'b1;
    tick();
    chk("accept edge o_tx_start", 32'(o_tx_start), 32'd0);
    chk("accept edge o_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_frame_req = 1'b0;
    tick();
    chk("first launch o_tx_start", 32'(o_tx_start), 32'd1);
    chk("first launch o_tx_byte", 32'(o_tx_byte), 32'hA5);
    wait_cnt(1, f0 + 1, 3000, "zero frame done");
    check_frame(b, 8'hB5, "zero");
    chk("done to LEN launch", 32'(lat_q[b + 1]), 32'd1);
    chk("done to HI launch", 32'(lat_q[b + 2]), 32'd2);
    chk("done to LO launch", 32'(lat_q[b + 3]), 32'd1);
    chk("done to CSUM launch", 32'(lat_q[b + 34]), 32'd1);
    chk("done to frame_done", 32'(fd_lat), 32'd1);
    chk("o_busy with frame_done", 32'(busy_at_fd), 32'd0);
    repeat (50) tick();
    chk("zero frame count", 32'(frames - f0), 32'd1);
    chk("zero frame no err", 32'(errs - e0), 32'd0);

    // Ramp buffer 0x0101*k: checksum A5.
    for (int k = 0; k < N_WORDS; k++) mem[k] = 16'(16'h0101 * k);
    b = bytes.size(); f0 = frames;
    pulse_req();
    wait_cnt(1, f0 + 1, 3000, "ramp frame done");
    check_frame(b, 8'hA5, "ramp");

    // Distinct high/low bytes 0x1200+k: checksum 4D, high byte first.
    for (int k = 0; k < N_WORDS; k++) mem[k] = 16'(16'h1200 + k);
    b = bytes.size(); f0 = frames;
    pulse_req();
    wait_cnt(1, f0 + 1, 3000, "order frame done");
    check_frame(b, 8'h4D, "order");
    chk("word0 high byte", 32'(bytes[b + 2]), 32'h12);
    chk("word0 low byte", 32'(bytes[b + 3]), 32'h00);
    chk("word1 low byte", 32'(bytes[b + 5]), 32'h01);

    // Two more requests mid-frame: exactly one extra frame, busy never drops in between.
    b = bytes.size(); f0 = frames; bf0 = busy_falls;
    pulse_req();
    wait_cnt(0, b + 5, 1000, "b2b reach byte 5");
    pulse_req();
    wait_cnt(0, b + 10, 1000, "b2b reach byte 10");
    pulse_req();
    wait_cnt(1, f0 + 2, 6000, "b2b two frames done");
    repeat (200) tick();
    chk("b2b frame count", 32'(frames - f0), 32'd2);
    chk("b2b byte count", 32'(bytes.size() - b), 32'd70);
    chk("b2b busy falls", 32'(busy_falls - bf0), 32'd1);
    check_frame(b, 8'h4D, "b2b first");
    check_frame(b + 35, 8'h4D, "b2b second");

    // Done withheld after the 5th byte: abort exactly TIMEOUT cycles after that launch.
    b = bytes.size(); f0 = frames; e0 = errs;
    withhold_at = tx_launches + 5;
    pulse_req();
    wait_cnt(2, e0 + 1, 2000, "timeout abort seen");
    chk("timeout err count", 32'(errs - e0), 32'd1);
    chk("timeout latency", 32'(err_cyc - lcyc[b + 4]), 32'(TIMEOUT));
    chk("timeout o_busy", 32'(busy_at_err), 32'd0);
    chk("timeout o_rd_addr", 32'(addr_at_err), 32'd0);
    chk("timeout byte count", 32'(bytes.size() - b), 32'd5);
    chk("timeout no frame_done", 32'(frames - f0), 32'd0);
    repeat (50) tick();
    withhold_at = 0;
    b = bytes.size(); f0 = frames;
    pulse_req();
    wait_cnt(1, f0 + 1, 3000, "post-abort frame done");
    check_frame(b, 8'h4D, "post-abort");

    // Transmitter busy at request time: nothing launches until it frees.
    b = bytes.size(); f0 = frames;
    @(negedge i_clk);
    force_busy  = 1'b1;
    i_frame_req = 1'b1;
    repeat (20) tick();
    chk("held busy no launch", 32'(bytes.size() - b), 32'd0);
    chk("held busy not accepted", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    force_busy = 1'b0;
    tick();
    chk("release accept o_tx_start", 32'(o_tx_start), 32'd0);
    chk("release accept o_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_frame_req = 1'b0;
    tick();
    chk("release launch o_tx_start", 32'(o_tx_start), 32'd1);
    chk("release launch o_tx_byte", 32'(o_tx_byte), 32'hA5);
    wait_cnt(1, f0 + 1, 3000, "release frame done");
    repeat (100) tick();
    chk("release frame count", 32'(frames - f0), 32'd1);
    check_frame(b, 8'h4D, "release");

    // Reset during word 7.
    b = bytes.size(); f0 = frames;
    pulse_req();
    wait_cnt(0, b + 17, 2000, "reach word 7");
    repeat (5) tick();
    chk("pre-reset o_rd_addr", 32'(o_rd_addr), 32'd7);
    chk("pre-reset o_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("mid reset o_busy", 32'(o_busy), 32'd0);
    chk("mid reset o_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("mid reset o_tx_start", 32'(o_tx_start), 32'd0);
    chk("mid reset o_tx_byte", 32'(o_tx_byte), 32'd0);
    chk("mid reset o_frame_done", 32'(o_frame_done), 32'd0);
    chk("mid reset o_err", 32'(o_err), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (60) tick();
    b = bytes.size(); f0 = frames; e0 = errs;
    pulse_req();
    wait_cnt(1, f0 + 1, 3000, "post-reset frame done");
    check_frame(b, 8'h4D, "post-reset");
    chk("post-reset no err", 32'(errs - e0), 32'd0);

    chk("launch while tx busy", 32'(start_busy_viol), 32'd0);
    chk("o_tx_byte changed between launches", 32'(stable_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
